// File: rtl/write_back_cache_pkg.sv
// rtl/write_back_cache_pkg.sv - shared widths, FSM encoding and byte-merge helper
package write_back_cache_pkg;
   localparam int WORD_BITWIDTH              = 32;
   localparam int ZEROS_BITWIDTH             = 2;
   localparam int DEFAULT_LINE_IX_BITWIDTH   = 8;
   localparam int DEFAULT_COLUMN_IX_BITWIDTH = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      WRITEBACK = 3'd2,
      FILL      = 3'd3,
      RETRY     = 3'd4
   } state_t;

   function automatic logic [WORD_BITWIDTH-1:0] merge_bytes(
      input logic [WORD_BITWIDTH-1:0] old_word,
      input logic [WORD_BITWIDTH-1:0] new_word,
      input logic [3:0]               strobe
   );
      logic [WORD_BITWIDTH-1:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strobe[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
      return merged;
   endfunction
endpackage

// File: rtl/write_back_cache_spbram.sv
// rtl/write_back_cache_spbram.sv - single-port block RAM, read-first, registered output
module write_back_cache_spbram
   import write_back_cache_pkg::*;
#(
   parameter int DATA_BITWIDTH = WORD_BITWIDTH,
   parameter int ADDR_BITWIDTH = DEFAULT_LINE_IX_BITWIDTH
) (
   input  logic                     clk,
   input  logic                     write_enable,
   input  logic [ADDR_BITWIDTH-1:0] address,
   input  logic [DATA_BITWIDTH-1:0] data_in,
   output logic [DATA_BITWIDTH-1:0] data_out
);
   logic [DATA_BITWIDTH-1:0] mem [2**ADDR_BITWIDTH];

   // No reset: contents survive rst_n, only the flop-based valid bits gate them.
   always_ff @(posedge clk) begin
      if (write_enable) mem[address] <= data_in;
      data_out <= mem[address];
   end
endmodule

// File: rtl/write_back_cache.sv
// rtl/write_back_cache.sv - direct-mapped write-back cache with burst fill and writeback
module write_back_cache
   import write_back_cache_pkg::*;
#(
   parameter int LINE_IX_BITWIDTH   = DEFAULT_LINE_IX_BITWIDTH,
   parameter int COLUMN_IX_BITWIDTH = DEFAULT_COLUMN_IX_BITWIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     write_enable,
   input  logic [3:0]               write_strobe,
   input  logic [WORD_BITWIDTH-1:0] address,
   input  logic [WORD_BITWIDTH-1:0] data_in,
   output logic [WORD_BITWIDTH-1:0] data_out,
   output logic                     ready,
   output logic                     busy,
   output logic [WORD_BITWIDTH-1:0] mem_address,
   output logic                     mem_read,
   input  logic                     mem_read_valid,
   input  logic [WORD_BITWIDTH-1:0] mem_data_in,
   output logic                     mem_write,
   input  logic                     mem_write_ack,
   output logic [WORD_BITWIDTH-1:0] mem_data_out
);
   localparam int TAG_BITWIDTH = WORD_BITWIDTH - LINE_IX_BITWIDTH - COLUMN_IX_BITWIDTH - ZEROS_BITWIDTH;
   localparam int COLUMNS      = 2**COLUMN_IX_BITWIDTH;
   localparam int LINES        = 2**LINE_IX_BITWIDTH;
   localparam int LINE_LSB     = COLUMN_IX_BITWIDTH + ZEROS_BITWIDTH;
   localparam int TAG_LSB      = LINE_LSB + LINE_IX_BITWIDTH;
   localparam logic [COLUMN_IX_BITWIDTH-1:0] LAST_BEAT = '1;
   localparam logic [COLUMN_IX_BITWIDTH-1:0] ONE_BEAT  = 1;
   localparam logic [LINE_LSB-1:0]           OFFSET_ZEROS = '0;

   state_t                          state;
   logic [LINES-1:0]                valid;
   logic [LINES-1:0]                dirty;
   logic [COLUMN_IX_BITWIDTH-1:0]   beat;
   logic [COLUMN_IX_BITWIDTH-1:0]   next_beat;
   logic                            req_write;
   logic [3:0]                      req_strobe;
   logic [WORD_BITWIDTH-1:0]        req_data;
   logic [TAG_BITWIDTH-1:0]         req_tag;
   logic [LINE_IX_BITWIDTH-1:0]     req_line;
   logic [COLUMN_IX_BITWIDTH-1:0]   req_column;

   logic [LINE_IX_BITWIDTH-1:0]     bram_line;
   logic [TAG_BITWIDTH-1:0]         tag_q;
   logic [WORD_BITWIDTH-1:0]        column_q [COLUMNS];
   logic [COLUMNS-1:0]              column_write;
   logic [WORD_BITWIDTH-1:0]        column_data;
   logic                            accept;
   logic                            hit;
   logic                            fill_beat;
   logic                            tag_write;
   logic                            unused_bits;

   assign unused_bits = ^address[ZEROS_BITWIDTH-1:0];
   assign accept      = (state == IDLE) && enable && !busy;
   assign bram_line   = (state == IDLE) ? address[TAG_LSB-1:LINE_LSB] : req_line;
   assign hit         = valid[req_line] && (tag_q == req_tag);
   assign fill_beat   = (state == FILL) && mem_read_valid;
   assign tag_write   = fill_beat && (beat == LAST_BEAT);
   assign next_beat   = beat + ONE_BEAT;
   assign column_data = fill_beat ? mem_data_in
                                  : merge_bytes(column_q[req_column], req_data, req_strobe);

   // Write ports: fill beats take priority, otherwise a write hit merges into its column.
   always_comb begin
      column_write = '0;
      if (fill_beat) column_write[beat] = 1'b1;
      else if ((state == LOOKUP) && hit && req_write) column_write[req_column] = 1'b1;
   end

   write_back_cache_spbram #(.DATA_BITWIDTH(TAG_BITWIDTH), .ADDR_BITWIDTH(LINE_IX_BITWIDTH)) u_tag_ram (
      .clk          (clk),
      .write_enable (tag_write),
      .address      (bram_line),
      .data_in      (req_tag),
      .data_out     (tag_q)
   );

   for (genvar c = 0; c < COLUMNS; c++) begin : g_column
      write_back_cache_spbram #(.DATA_BITWIDTH(WORD_BITWIDTH), .ADDR_BITWIDTH(LINE_IX_BITWIDTH)) u_data_ram (
         .clk          (clk),
         .write_enable (column_write[c]),
         .address      (bram_line),
         .data_in      (column_data),
         .data_out     (column_q[c])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         valid        <= '0;
         dirty        <= '0;
         beat         <= '0;
         ready        <= 1'b0;
         busy         <= 1'b0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         data_out     <= '0;
         mem_address  <= '0;
         mem_data_out <= '0;
         req_write    <= 1'b0;
         req_strobe   <= '0;
         req_data     <= '0;
         req_tag      <= '0;
         req_line     <= '0;
         req_column   <= '0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_write  <= write_enable;
                  req_strobe <= write_strobe;
                  req_data   <= data_in;
                  req_tag    <= address[WORD_BITWIDTH-1:TAG_LSB];
                  req_line   <= address[TAG_LSB-1:LINE_LSB];
                  req_column <= address[LINE_LSB-1:ZEROS_BITWIDTH];
                  state      <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                  if (!req_write) data_out <= column_q[req_column];
                  else if (|req_strobe) dirty[req_line] <= 1'b1;
               end else begin
                  busy <= 1'b1;
                  beat <= '0;
                  if (valid[req_line] && dirty[req_line]) begin
                     mem_write    <= 1'b1;
                     mem_address  <= {tag_q, req_line, OFFSET_ZEROS};
                     mem_data_out <= column_q[0];
                     state        <= WRITEBACK;
                  end else begin
                     mem_read    <= 1'b1;
                     mem_address <= {req_tag, req_line, OFFSET_ZEROS};
                     state       <= FILL;
                  end
               end
            end
            WRITEBACK: begin
               // Data RAMs are not written here, so column_q holds the victim line throughout.
               if (mem_write_ack) begin
                  beat <= next_beat;
                  if (beat == LAST_BEAT) begin
                     mem_write   <= 1'b0;
                     mem_read    <= 1'b1;
                     mem_address <= {req_tag, req_line, OFFSET_ZEROS};
                     state       <= FILL;
                  end else begin
                     mem_data_out <= column_q[next_beat];
                  end
               end
            end
            FILL: begin
               if (mem_read_valid) begin
                  beat <= next_beat;
                  if (beat == LAST_BEAT) begin
                     mem_read         <= 1'b0;
                     valid[req_line]  <= 1'b1;
                     dirty[req_line]  <= 1'b0;
                     state            <= RETRY;
                  end
               end
            end
            RETRY: begin
               // One cycle lets the RAMs present the freshly filled line before the re-lookup.
               state <= LOOKUP;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_write_back_cache.sv
// tb/tb_write_back_cache.sv - randomized bench against a flat-memory reference model
module tb_write_back_cache;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        write_enable = 1'b0;
   logic [3:0]  write_strobe = 4'h0;
   logic [31:0] address = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        ready;
   logic        busy;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_read_valid = 1'b0;
   logic [31:0] mem_data_in = '0;
   logic        mem_write;
   logic        mem_write_ack = 1'b0;
   logic [31:0] mem_data_out;

   write_back_cache dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .write_enable   (write_enable),
      .write_strobe   (write_strobe),
      .address        (address),
      .data_in        (data_in),
      .data_out       (data_out),
      .ready          (ready),
      .busy           (busy),
      .mem_address    (mem_address),
      .mem_read       (mem_read),
      .mem_read_valid (mem_read_valid),
      .mem_data_in    (mem_data_in),
      .mem_write      (mem_write),
      .mem_write_ack  (mem_write_ack),
      .mem_data_out   (mem_data_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // CPU-visible memory (what any read must return) and the backing store behind the cache.
   logic [31:0] cpu_view [logic [31:0]];
   logic [31:0] backing  [logic [31:0]];
   bit          dir_valid [256];
   bit          dir_dirty [256];
   logic [19:0] dir_tag   [256];

   int          exp_wb, exp_fill, wb_beat, fill_beat;
   logic [31:0] exp_wb_base, exp_fill_base;
   int          wr_cnt = 0, wr_target = 0, rd_cnt = 0, rd_target = 0, max_hold = 0;
   logic [31:0] seen_wb_base, seen_fill_base;
   logic [31:0] seen_wb_data [4];
   logic [31:0] rd, r_addr, r_data;
   logic [3:0]  r_strobe;
   bit          r_we;
   int          n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] view_word(input logic [31:0] a);
      return cpu_view.exists(a) ? cpu_view[a] : init_word(a);
   endfunction

   function automatic logic [31:0] backing_word(input logic [31:0] a);
      return backing.exists(a) ? backing[a] : init_word(a);
   endfunction

   task automatic predict(input logic [31:0] a, output bit hitp);
      int line;
      line = int'(a[11:4]);
      hitp = dir_valid[line] && (dir_tag[line] == a[31:12]);
      exp_wb        = (!hitp && dir_valid[line] && dir_dirty[line]) ? 4 : 0;
      exp_wb_base   = {dir_tag[line], a[11:4], 4'h0};
      exp_fill      = hitp ? 0 : 4;
      exp_fill_base = {a[31:4], 4'h0};
      wb_beat   = 0;
      fill_beat = 0;
   endtask

   task automatic model_reset();
      foreach (dir_valid[i]) begin
         dir_valid[i] = 1'b0;
         dir_dirty[i] = 1'b0;
      end
      cpu_view.delete();
      foreach (backing[k]) cpu_view[k] = backing[k];
   endtask

   task automatic do_req(input bit we, input logic [3:0] st, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rdata);
      bit          hitp, got;
      int          lat, line;
      logic [31:0] w;
      predict(a, hitp);
      line = int'(a[11:4]);
      @(negedge clk);
      enable = 1'b1; write_enable = we; write_strobe = st; address = a; data_in = d;
      @(posedge clk);
      lat = 0; got = 1'b0;
      while (!got && lat < 300) begin
         @(posedge clk);
         lat++;
         #1;
         if (ready) got = 1'b1;
      end
      check("ready_seen", {31'd0, got}, 32'd1);
      rdata = data_out;
      if (!we) check("read_data", data_out, view_word(a));
      if (hitp) check("hit_latency", lat, 32'd1);
      else      check("miss_latency_min", {31'd0, lat >= exp_wb + exp_fill + 2}, 32'd1);
      check("writeback_beats", wb_beat, exp_wb);
      check("fill_beats", fill_beat, exp_fill);
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("ready_single_pulse", {31'd0, ready}, 32'd0);
      if (!hitp) begin
         dir_valid[line] = 1'b1;
         dir_tag[line]   = a[31:12];
         dir_dirty[line] = 1'b0;
      end
      if (we) begin
         if (st != 4'h0) dir_dirty[line] = 1'b1;
         w = view_word(a);
         for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = d[8*b +: 8];
         cpu_view[a] = w;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"},        {31'd0, ready},     32'd0);
      check({tag, "_busy"},         {31'd0, busy},      32'd0);
      check({tag, "_mem_read"},     {31'd0, mem_read},  32'd0);
      check({tag, "_mem_write"},    {31'd0, mem_write}, 32'd0);
      check({tag, "_data_out"},     data_out,           32'd0);
      check({tag, "_mem_address"},  mem_address,        32'd0);
      check({tag, "_mem_data_out"}, mem_data_out,       32'd0);
   endtask

   // Memory side: random-latency responder plus every-cycle protocol checks.
   always @(negedge clk) begin
      mem_write_ack  = 1'b0;
      mem_read_valid = 1'b0;
      if (!rst_n) begin
         wr_cnt = 0;
         rd_cnt = 0;
      end else begin
         check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
         if (mem_read || mem_write) check("busy_during_mem", {31'd0, busy}, 32'd1);
         if (mem_write) begin
            check("wb_expected", {31'd0, wb_beat < exp_wb}, 32'd1);
            check("wb_address", mem_address, exp_wb_base);
            check("wb_data", mem_data_out, view_word(exp_wb_base + 32'(4 * wb_beat)));
            if (wb_beat == 0) seen_wb_base = mem_address;
            if (wr_cnt >= wr_target) begin
               mem_write_ack = 1'b1;
               backing[exp_wb_base + 32'(4 * wb_beat)] = mem_data_out;
               if (wb_beat < 4) seen_wb_data[wb_beat] = mem_data_out;
               wb_beat++;
               wr_cnt    = 0;
               wr_target = int'($urandom_range(0, 2));
            end else begin
               wr_cnt++;
               if (wr_cnt > max_hold) max_hold = wr_cnt;
            end
         end else if (mem_read) begin
            check("fill_expected", {31'd0, fill_beat < exp_fill}, 32'd1);
            check("fill_address", mem_address, exp_fill_base);
            seen_fill_base = mem_address;
            if (rd_cnt >= rd_target) begin
               mem_read_valid = 1'b1;
               mem_data_in    = backing_word(exp_fill_base + 32'(4 * fill_beat));
               fill_beat++;
               rd_cnt    = 0;
               rd_target = int'($urandom_range(0, 2));
            end else begin
               rd_cnt++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_wb = 0; exp_fill = 0; wb_beat = 0; fill_beat = 0;
      exp_wb_base = '0; exp_fill_base = '0;
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("reset_async");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_outputs_zero("after_reset");

      // Cold read: line fill from 0x1000, first word returned.
      do_req(1'b0, 4'h0, 32'h0000_1000, 32'h0, rd);
      check("cold_read_literal", rd, 32'h5A5A_1000);
      check("cold_fill_base", seen_fill_base, 32'h0000_1000);

      do_req(1'b1, 4'hF, 32'h0000_1004, 32'hDEAD_BEEF, rd);
      do_req(1'b0, 4'h0, 32'h0000_1004, 32'h0, rd);
      check("write_read_literal", rd, 32'hDEAD_BEEF);

      // Eviction of the dirty line, with the first writeback ack held off five cycles.
      max_hold  = 0;
      wr_target = 5;
      do_req(1'b0, 4'h0, 32'h0000_5000, 32'h0, rd);
      check("evict_wb_base", seen_wb_base, 32'h0000_1000);
      check("evict_wb_beat1", seen_wb_data[1], 32'hDEAD_BEEF);
      check("evict_fill_base", seen_fill_base, 32'h0000_5000);
      check("ack_hold_cycles", max_hold, 32'd5);
      check("evict_read_literal", rd, 32'h5A5A_5000);

      do_req(1'b1, 4'hF, 32'h0000_5008, 32'hAAAA_AAAA, rd);
      do_req(1'b1, 4'h3, 32'h0000_5008, 32'h1234_5678, rd);
      do_req(1'b0, 4'h0, 32'h0000_5008, 32'h0, rd);
      check("partial_strobe_literal", rd, 32'hAAAA_5678);

      // A zero-strobe write must not make the line dirty: the next eviction has no writeback.
      do_req(1'b0, 4'h0, 32'h0000_2040, 32'h0, rd);
      do_req(1'b1, 4'h0, 32'h0000_2044, 32'hFFFF_FFFF, rd);
      do_req(1'b0, 4'h0, 32'h0000_6040, 32'h0, rd);

      // Reset in the middle of a fill, then the same address must miss again.
      predict(32'h0000_7080, r_we);
      @(negedge clk);
      enable = 1'b1; write_enable = 1'b0; write_strobe = 4'h0; address = 32'h0000_7080;
      n = 0;
      while (fill_beat < 2 && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("reset_test_beat", fill_beat, 32'd2);
      rst_n = 1'b0;
      #1 check_outputs_zero("mid_fill_reset");
      enable = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      do_req(1'b0, 4'h0, 32'h0000_7080, 32'h0, rd);
      check("refill_after_reset_base", seen_fill_base, 32'h0000_7080);

      for (int i = 0; i < 200; i++) begin
         r_addr   = 32'($urandom_range(0, 3)) * 32'h1000 + 32'($urandom_range(0, 3)) * 32'h10
                  + 32'($urandom_range(0, 3)) * 32'h4;
         r_we     = 1'($urandom_range(0, 1));
         r_strobe = 4'($urandom_range(0, 15));
         r_data   = $urandom;
         do_req(r_we, r_strobe, r_addr, r_data, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
